// File: rtl/regf_pkg.sv
// +--------------------------------------------------------------------+
// | regf_pkg : default sizes and word/address types for regf_sb.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package regf_pkg;
  localparam int REGF_DATA_W = 32;
  localparam int REGF_ADDR_W = 5;
  localparam int REGF_NUM_RD = 2;

  typedef logic [REGF_ADDR_W-1:0] regf_addr_t;
  typedef logic [REGF_DATA_W-1:0] regf_word_t;
endpackage

`default_nettype wire

// File: rtl/regf_scoreboard.sv
// +--------------------------------------------------------------------+
// | regf_scoreboard : per-register busy bits, busy count, reserve error.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module regf_scoreboard
  import regf_pkg::*;
#(
  parameter int ADDR_W   = REGF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic                    resv_en,
  input  logic [ADDR_W-1:0]       resv_addr,
  output logic [(2**ADDR_W)-1:0]  busy,
  output logic [ADDR_W:0]         busy_cnt,
  output logic                    resv_err
);

  localparam int          DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  busy_cnt_q, busy_cnt_d;
  logic             resv_err_q, resv_err_d;
  logic             wr_ok, rv_ok, inc, dec;

  always_comb begin
    wr_ok = wr_en   && !((ZERO_REG != 0) && (wr_addr   == '0));
    rv_ok = resv_en && !((ZERO_REG != 0) && (resv_addr == '0));

    // Reserve is applied after the write so a same-address producer wins.
    busy_d = busy_q;
    if (wr_ok) busy_d[wr_addr]   = 1'b0;
    if (rv_ok) busy_d[resv_addr] = 1'b1;

    inc = rv_ok && !busy_q[resv_addr];
    dec = wr_ok && busy_q[wr_addr] && !(rv_ok && (resv_addr == wr_addr));

    busy_cnt_d = busy_cnt_q;
    if (inc && !dec)      busy_cnt_d = busy_cnt_q + CNT_ONE;
    else if (dec && !inc) busy_cnt_d = busy_cnt_q - CNT_ONE;

    resv_err_d = rv_ok && busy_q[resv_addr] && !(wr_ok && (wr_addr == resv_addr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      resv_err_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      resv_err_q <= resv_err_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;
  assign resv_err = resv_err_q;

endmodule

`default_nettype wire

// File: rtl/regf_sb.sv
// +--------------------------------------------------------------------+
// | regf_sb : multi-port register file with pending-register scoreboard.|
// | Optional write-through forwarding: define REGF_BYPASS_EN. Rev 1.0  |
// +--------------------------------------------------------------------+
`default_nettype none

module regf_sb
  import regf_pkg::*;
#(
  parameter int DATA_W   = REGF_DATA_W,
  parameter int ADDR_W   = REGF_ADDR_W,
  parameter int NUM_RD   = REGF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       resv_en,
  input  logic [ADDR_W-1:0]          resv_addr,
  output logic [ADDR_W:0]            busy_cnt,
  output logic                       resv_err
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;

  regf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .busy      (busy),
    .busy_cnt  (busy_cnt),
    .resv_err  (resv_err)
  );

  always_comb begin
    wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_addr] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
`ifdef REGF_BYPASS_EN
    logic hit;
    assign hit = wr_en && (wr_addr == addr) && !is_zero;
    assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? wr_data : mem_q[addr]);
    assign rd_busy[p] = is_zero ? 1'b0 :
                        (hit ? (resv_en && (resv_addr == addr)) : busy[addr]);
`else
    assign rd_data[p*DATA_W +: DATA_W] = is_zero ? '0 : mem_q[addr];
    assign rd_busy[p] = is_zero ? 1'b0 : busy[addr];
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_regf_sb.sv
// +--------------------------------------------------------------------+
// | tb_regf_sb : self-checking bench for regf_sb (default and 16/3/3). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_regf_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en, resv_en;
  logic [4:0]  wr_addr, resv_addr;
  logic [31:0] wr_data;
  logic [5:0]  busy_cnt;
  logic        resv_err;

  logic [8:0]  s_rd_addr;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic        s_wr_en, s_resv_en;
  logic [2:0]  s_wr_addr, s_resv_addr;
  logic [15:0] s_wr_data;
  logic [3:0]  s_busy_cnt;
  logic        s_resv_err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] exp;

  always #5 clk = ~clk;

  regf_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .resv_en(resv_en),
    .resv_addr(resv_addr), .busy_cnt(busy_cnt), .resv_err(resv_err)
  );

  regf_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1)) dut_s (
    .clk(clk), .rst(rst), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .resv_en(s_resv_en),
    .resv_addr(s_resv_addr), .busy_cnt(s_busy_cnt), .resv_err(s_resv_err)
  );

  task automatic idle();
    wr_en = 1'b0; resv_en = 1'b0; s_wr_en = 1'b0; s_resv_en = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    resv_en = 1'b1; resv_addr = 5'd7;
    exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd1);
    cycle(); idle();
    rd_addr = {5'd7, 5'd5}; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== exp) $display("FAIL pre_reset_data got=%h exp=%h", rd_data[31:0], exp); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL pre_reset_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    #2 rst = 1'b1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== exp) $display("FAIL reset_data got=%h exp=%h", rd_data[31:0], exp); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy !== exp[1:0]) $display("FAIL reset_busy got=%b exp=%b", rd_busy, exp[1:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL reset_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    cycle(); rst = 1'b0; cycle();
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    resv_en = 1'b1; resv_addr = 5'd0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    cycle(); idle();
    rd_addr = {5'd0, 5'd0}; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== exp) $display("FAIL zero_data got=%h exp=%h", rd_data[31:0], exp); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy !== exp[1:0]) $display("FAIL zero_busy got=%b exp=%b", rd_busy, exp[1:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL zero_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
  endtask

  task automatic test_scoreboard();
    idle(); resv_en = 1'b1; resv_addr = 5'd3; exp_q.push_back(32'd1);
    cycle(); idle();
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL sb_cnt1 got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    resv_en = 1'b1; resv_addr = 5'd9; exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    cycle(); idle();
    rd_addr = {5'd9, 5'd3}; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL sb_cnt2 got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy !== exp[1:0]) $display("FAIL sb_busy2 got=%b exp=%b", rd_busy, exp[1:0]); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    exp_q.push_back(32'd1); exp_q.push_back(32'b10); exp_q.push_back(32'hA5A5A5A5);
    cycle(); idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL sb_cnt_wr got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy !== exp[1:0]) $display("FAIL sb_busy_wr got=%b exp=%b", rd_busy, exp[1:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== exp) $display("FAIL sb_data_wr got=%h exp=%h", rd_data[31:0], exp); else n_pass++;
    // Release r9, then write an idle register: count must settle and stay at 0.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9; cycle();
    wr_addr = 5'd3; wr_data = 32'h33; exp_q.push_back(32'd0);
    cycle(); idle();
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL sb_cnt_idle_wr got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
  endtask

  task automatic test_collision();
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h11; resv_en = 1'b1; resv_addr = 5'd4;
    exp_q.push_back(32'h11); exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    cycle(); idle();
    rd_addr = {5'd10, 5'd4}; #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[31:0] !== exp) $display("FAIL col_data got=%h exp=%h", rd_data[31:0], exp); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy[0] !== exp[0]) $display("FAIL col_busy got=%b exp=%b", rd_busy[0], exp[0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL col_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (resv_err !== exp[0]) $display("FAIL col_no_err got=%b exp=%b", resv_err, exp[0]); else n_pass++;
    resv_en = 1'b1; resv_addr = 5'd4;
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    cycle(); idle();
    exp = exp_q.pop_front(); n_checks++;
    if (resv_err !== exp[0]) $display("FAIL col_err_pulse got=%b exp=%b", resv_err, exp[0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL col_err_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    cycle();
    exp = exp_q.pop_front(); n_checks++;
    if (resv_err !== exp[0]) $display("FAIL col_err_one_cycle got=%b exp=%b", resv_err, exp[0]); else n_pass++;
    // Write busy r4 while reserving idle r10: -1 and +1 cancel.
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44; resv_en = 1'b1; resv_addr = 5'd10;
    exp_q.push_back(32'd1); exp_q.push_back(32'b10);
    cycle(); idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL diff_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy !== exp[1:0]) $display("FAIL diff_busy got=%b exp=%b", rd_busy, exp[1:0]); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hA; cycle(); idle();
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1111; cycle(); idle();
    rd_addr = {5'd6, 5'd0};
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D;
`ifdef REGF_BYPASS_EN
    exp_q.push_back(32'hCAFEF00D);
`else
    exp_q.push_back(32'h1111);
`endif
    exp_q.push_back(32'hCAFEF00D);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[63:32] !== exp) $display("FAIL byp_same_cycle got=%h exp=%h", rd_data[63:32], exp); else n_pass++;
    cycle(); idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_data[63:32] !== exp) $display("FAIL byp_next_cycle got=%h exp=%h", rd_data[63:32], exp); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h6; resv_en = 1'b1; resv_addr = 5'd6;
`ifdef REGF_BYPASS_EN
    exp_q.push_back(32'd1);
`else
    exp_q.push_back(32'd0);
`endif
    exp_q.push_back(32'd1);
    #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy[1] !== exp[0]) $display("FAIL byp_busy_same got=%b exp=%b", rd_busy[1], exp[0]); else n_pass++;
    cycle(); idle(); #1;
    exp = exp_q.pop_front(); n_checks++;
    if (rd_busy[1] !== exp[0]) $display("FAIL byp_busy_next got=%b exp=%b", rd_busy[1], exp[0]); else n_pass++;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h6; cycle(); idle();
  endtask

  task automatic test_params();
    logic [15:0] model [8];
    idle();
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_addr = 3'(i); s_wr_data = 16'hA000 + 16'(i * 16'h111);
      model[i] = (i == 0) ? 16'h0 : s_wr_data;
      cycle();
    end
    idle();
    for (int t = 0; t < 4; t++) begin
      logic [2:0] a0, a1, a2;
      a0 = 3'(t * 3); a1 = 3'(t * 3 + 1); a2 = 3'(t * 3 + 2);
      s_rd_addr = {a2, a1, a0};
      exp_q.push_back({16'h0, model[a0]}); exp_q.push_back({16'h0, model[a1]}); exp_q.push_back({16'h0, model[a2]});
      #1;
      exp = exp_q.pop_front(); n_checks++;
      if (s_rd_data[15:0] !== exp[15:0]) $display("FAIL par_p0 a=%0d got=%h exp=%h", a0, s_rd_data[15:0], exp[15:0]); else n_pass++;
      exp = exp_q.pop_front(); n_checks++;
      if (s_rd_data[31:16] !== exp[15:0]) $display("FAIL par_p1 a=%0d got=%h exp=%h", a1, s_rd_data[31:16], exp[15:0]); else n_pass++;
      exp = exp_q.pop_front(); n_checks++;
      if (s_rd_data[47:32] !== exp[15:0]) $display("FAIL par_p2 a=%0d got=%h exp=%h", a2, s_rd_data[47:32], exp[15:0]); else n_pass++;
    end
    for (int i = 0; i < 8; i++) begin
      s_resv_en = 1'b1; s_resv_addr = 3'(i); cycle();
    end
    idle();
    exp_q.push_back(32'd7);
    exp = exp_q.pop_front(); n_checks++;
    if (s_busy_cnt !== exp[3:0]) $display("FAIL par_cnt_full got=%0d exp=%0d", s_busy_cnt, exp[3:0]); else n_pass++;
    s_rd_addr = {3'd7, 3'd1, 3'd0}; #1;
    exp_q.push_back(32'b110);
    exp = exp_q.pop_front(); n_checks++;
    if (s_rd_busy !== exp[2:0]) $display("FAIL par_busy got=%b exp=%b", s_rd_busy, exp[2:0]); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; resv_addr = '0;
    s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0; s_resv_addr = '0;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp = exp_q.pop_front(); n_checks++;
    if (busy_cnt !== exp[5:0]) $display("FAIL init_cnt got=%0d exp=%0d", busy_cnt, exp[5:0]); else n_pass++;
    exp = exp_q.pop_front(); n_checks++;
    if (resv_err !== exp[0]) $display("FAIL init_err got=%b exp=%b", resv_err, exp[0]); else n_pass++;
    cycle(); cycle(); rst = 1'b0; cycle();
    test_reset();
    test_zero_reg();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_params();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regf_sb.md
Name: regf_sb

Overview:
- Parametrised multi-port register file with a built-in register-pending scoreboard.
- Successor to the fixed 32x32, 2-read/1-write datapath register memory.
- Adds configurable width, depth and read-port count, a hardwired zero register, asynchronous clear, per-register busy tracking for long-latency producers (loads, multiply/divide), and optional write-to-read bypass.
- Sits in the decode stage: decode reads operands and reserves destinations; write-back writes results and releases them.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads as 0 and ignores writes and reservations.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational from rd_addr.
- rd_busy  out  NUM_RD  per port: addressed register has a pending producer.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back destination.
- wr_data  in  DATA_W  write-back value.
- resv_en  in  1  reserve a destination (mark busy).
- resv_addr  in  ADDR_W  register to reserve.
- busy_cnt  out  ADDR_W+1  number of registers currently busy.
- resv_err  out  1  registered one-cycle pulse: reservation hit an already-busy register.

Behaviour:
- Reset (async, rst=1):
  - All DEPTH registers cleared to 0.
  - All busy bits cleared.
  - busy_cnt=0, resv_err=0.
  - Reset asserted mid-operation discards in-flight reservations immediately; no clock needed.
- Reads:
  - Purely combinational, zero latency.
  - rd_data[i] = mem[rd_addr[i]].
  - rd_busy[i] = busy[rd_addr[i]].
  - With ZERO_REG=1 and rd_addr[i]=0: rd_data[i]=0 and rd_busy[i]=0 always.
- Write (posedge clk, wr_en=1):
  - mem[wr_addr] <= wr_data.
  - busy[wr_addr] <= 0.
  - Ignored entirely when ZERO_REG=1 and wr_addr=0.
- Reserve (posedge clk, resv_en=1):
  - busy[resv_addr] <= 1.
  - Ignored when ZERO_REG=1 and resv_addr=0.
- Simultaneous write and reserve, same address:
  - Data is written.
  - Busy ends at 1 (the new producer wins).
  - busy_cnt unchanged if the register was already busy; +1 if it was not.
- Simultaneous write and reserve, different addresses: both take effect; busy_cnt changes by (+1 if the newly reserved register was idle) + (-1 if the written register was busy).
- Write to a non-busy register: legal; busy stays 0; busy_cnt unchanged.
- Reserve of an already-busy register (without a same-address write that cycle):
  - Busy stays 1; busy_cnt unchanged.
  - resv_err=1 on the following cycle for exactly one cycle.
- busy_cnt:
  - Registered, updated incrementally each cycle; never wraps.
  - Maximum is DEPTH-ZERO_REG.
  - Must always equal the popcount of the busy vector.
- Multiple read ports addressing the same register return identical values.

Optional Feature:
- Macro REGF_BYPASS_EN.
- Defined: write-through forwarding. When wr_en=1 and wr_addr=rd_addr[i] (and that address is not the hardwired zero register):
  - rd_data[i] = wr_data in the same cycle.
  - rd_busy[i] = 0, unless resv_en=1 with resv_addr=rd_addr[i] that same cycle, in which case rd_busy[i]=1.
- Undefined: reads always return stored contents and the stored busy bit; the new value is visible the cycle after the write.

Decomposition:
- Package regf_pkg holds:
  - default constants REGF_DATA_W=32, REGF_ADDR_W=5, REGF_NUM_RD=2;
  - a typedef for the register address;
  - a typedef for the register word.
- Sub-module regf_scoreboard is natural:
  - owns the busy vector, busy_cnt and resv_err;
  - inputs: wr_en/wr_addr, resv_en/resv_addr;
  - output: busy vector to the top.
- Storage array and read muxing/bypass stay in regf_sb.

Test Plan:
- Reset: write 0xDEADBEEF to r5; reserve r7; assert rst asynchronously between edges. Expect r5 reads 0, rd_busy=0, busy_cnt=0 with no clock edge.
- Zero register: write 0x12345678 to r0 and reserve r0. Expect rd_data=0, rd_busy=0, busy_cnt=0.
- Scoreboard life cycle:
  - Reserve r3, then r9. Expect busy_cnt=1, then 2.
  - Write r3=0xA5A5A5A5. Expect busy_cnt=1, rd_busy for r3=0, data 0xA5A5A5A5.
- Collision: in the same cycle write r4=0x11 and reserve r4 (r4 idle). Expect r4=0x11, busy=1, busy_cnt=1. Re-reserve r4 next cycle. Expect resv_err pulse for one cycle and busy_cnt still 1.
- Bypass: write r6=0xCAFEF00D while rd_addr[1]=6.
  - With REGF_BYPASS_EN: rd_data[1]=0xCAFEF00D in the same cycle.
  - Without: old value in that cycle, new value the next cycle.
- Parameters: DATA_W=16, ADDR_W=3, NUM_RD=3. Fill all 8 registers, then read three different addresses per cycle. Expect correct values; reserving all 7 non-zero registers gives busy_cnt=7.
